dbg_trace_capture: RTL and testbench
====================================

// Module: dbg_trace_capture
// PURPOSE
//  Trigger-based trace buffer on the OR-combined debug data bus (dout) of the
//  debug-select mux tree. It samples the bus into a circular buffer until a
//  masked trigger matches, then takes a programmed number of post-trigger
//  samples. It freezes the buffer and drains it oldest-first over a
//  valid/ready read port.
// PARAMETERS
//  WIDTH   8   debug bus width
//  DEPTH   16  buffer entries; power of two, >=4
//  CNT_W   5   width of post_cnt and internal fill count ($clog2(DEPTH)+1)
// PORTS
//  clk       in   1      rising-edge clock
//  rstn      in   1      reset, synchronous, active-low
//  din       in   WIDTH  debug data bus, sampled every cycle while capturing
//  arm       in   1      1-cycle pulse: start (or restart) a capture
//  trig_val  in   WIDTH  trigger compare value
//  trig_msk  in   WIDTH  trigger mask; 1 = bit compared
//  post_cnt  in   CNT_W  samples stored after the trigger sample
//  rd_vld    out  1      rd_data holds a valid stored sample
//  rd_rdy    in   1      consumer accepts sample
//  rd_data   out  WIDTH  stored sample, oldest first
//  rd_last   out  1      with rd_vld: final sample of capture
//  state     out  2      0 IDLE, 1 ARMED, 2 POST, 3 DONE
//  triggered out  1      trigger seen in current capture; cleared by arm
// BEHAVIOUR
//  Reset (rstn=0 at a clk edge): state=IDLE; rd_vld=0; rd_last=0; rd_data=0;
//   triggered=0; wr_ptr=0; fill=0. Memory contents are don't-care.
//  Reset wins over every other input, including mid-capture or mid-drain.
//  arm=1 in any state: next state=ARMED, wr_ptr=0, fill=0, triggered=0.
//   post_cnt is latched at this edge as pc=min(post_cnt,DEPTH-1).
//   Any in-progress drain is aborted; rd_vld=0 in the following cycle.
//  Sampling begins in the cycle after the arm edge; din is not sampled in the
//   arm cycle itself.
//  ARMED: each cycle, mem[wr_ptr]<=din; wr_ptr+1 mod DEPTH;
//   fill saturates at DEPTH.
//   hit = ((din ^ trig_val) & trig_msk) == 0. Mask 0 hits on first sample.
//   On hit, the hit sample is stored and triggered<=1.
//   pc==0: next state DONE. Otherwise: next state POST with rem=pc.
//  POST: store din each cycle as in ARMED; rem decrements.
//   The cycle that stores the sample with rem==1 goes to DONE.
//   No trigger is evaluated in POST.
//  DONE: no writes. rd_ptr=(wr_ptr-fill) mod DEPTH; rd_cnt=fill.
//   rd_vld=1 while rd_cnt>0, starting 1 cycle after entering DONE.
//   Transfer on rd_vld&rd_rdy: rd_ptr+1, rd_cnt-1.
//   rd_data/rd_last stay stable while rd_vld&!rd_rdy.
//   rd_last=1 when rd_cnt==1.
//   The transfer with rd_last goes to IDLE; rd_vld=0 next cycle.
//  Trigger sample is always in the buffer. Pre-trigger history = fill-1-pc,
//   which is 0 when the trigger hits on the first ARMED sample.
//  Wrap-around: wr_ptr wraps freely. Once fill==DEPTH, the oldest entry is
//   overwritten.
//  IDLE: din ignored, rd_vld=0, buffer retained but not readable.
//  Throughput: one sample per cycle when rd_rdy is held high.
// TESTING
//  Reset: rstn=0 mid-POST and with rd_vld=1
//   -> IDLE, rd_vld=0, triggered=0 on the next cycle.
//  Ramp: arm; din=0,1,2,...; trig_val=8'h05, msk=8'hFF, post_cnt=2
//   -> drains 0..7 (8 samples), rd_last on 7, triggered=1.
//  Wrap/overwrite: DEPTH=16, trigger at din=8'd40, post_cnt=3
//   -> drains 28..43 (16 samples), rd_last on 43.
//  Clamp and mask: post_cnt=31, msk=8'h00 -> trigger on first sample;
//   drains 16 samples, trigger sample is first.
//  Backpressure: random rd_rdy (~50%)
//   -> every sample delivered once, in order; data stable while stalled.
//  Re-arm: arm mid-drain after 3 transfers
//   -> rd_vld=0 next cycle; new capture is correct; old data never appears.

Source files
------------

// File: rtl/dbg_trace_capture.sv
// dbg_trace_capture: trigger-based trace buffer on the debug data bus.
// Once armed, din is written into a circular buffer every cycle until a masked
// trigger matches. A programmed number of post-trigger samples is then taken,
// the buffer is frozen, and it is drained oldest-first on a valid/ready port.
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   din[WIDTH]                 debug data bus
//   arm                        1-cycle pulse that starts or restarts a capture
//   trig_val, trig_msk[WIDTH]  trigger compare value and mask (1 = bit compared)
//   post_cnt[CNT_W]            samples stored after the trigger sample
//   rd_vld, rd_rdy             read handshake
//   rd_data[WIDTH], rd_last    stored sample, final-sample flag
//   state[2]                   0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   triggered                  trigger seen in the current capture
module dbg_trace_capture #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  input  logic             arm,
  input  logic [WIDTH-1:0] trig_val,
  input  logic [WIDTH-1:0] trig_msk,
  input  logic [CNT_W-1:0] post_cnt,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_last,
  output logic [1:0]       state,
  output logic             triggered
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] fill;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] pc;
  logic [CNT_W-1:0] rem;

  logic [1:0]       state_nxt;
  logic             hit;
  logic             do_wr;
  logic             xfer;
  logic             load;
  logic [CNT_W-1:0] fill_inc;
  logic [AW-1:0]    wr_ptr_inc;
  logic [CNT_W-1:0] pc_clamp;

  assign fill_inc   = (fill == CNT_W'(DEPTH)) ? fill : fill + CNT_W'(1);
  assign wr_ptr_inc = wr_ptr + AW'(1);
  assign pc_clamp   = (post_cnt > CNT_W'(DEPTH - 1)) ? CNT_W'(DEPTH - 1) : post_cnt;

  // Next-state and per-cycle control; arm overrides everything but reset.
  always_comb begin
    state_nxt = state;
    hit       = ((din ^ trig_val) & trig_msk) == '0;
    do_wr     = 1'b0;
    xfer      = rd_vld & rd_rdy;
    load      = 1'b0;
    if (arm) begin
      state_nxt = S_ARMED;
    end else begin
      case (state)
        S_ARMED: begin
          do_wr = 1'b1;
          if (hit) state_nxt = (pc == '0) ? S_DONE : S_POST;
        end
        S_POST: begin
          do_wr = 1'b1;
          if (rem == CNT_W'(1)) state_nxt = S_DONE;
        end
        S_DONE: begin
          // Refill the output register when it is empty or being consumed.
          load = (rd_cnt != '0) && (!rd_vld || rd_rdy);
          if (xfer && rd_last) state_nxt = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  // Sample storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (rstn && do_wr) mem[wr_ptr] <= din;
  end

  // State register and datapath.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      rd_cnt    <= '0;
      pc        <= '0;
      rem       <= '0;
      rd_vld    <= 1'b0;
      rd_last   <= 1'b0;
      rd_data   <= '0;
      triggered <= 1'b0;
    end else begin
      state <= state_nxt;
      if (arm) begin
        wr_ptr    <= '0;
        fill      <= '0;
        triggered <= 1'b0;
        pc        <= pc_clamp;
        rd_vld    <= 1'b0;
        rd_last   <= 1'b0;
      end else begin
        if (do_wr) begin
          wr_ptr <= wr_ptr_inc;
          fill   <= fill_inc;
        end
        if (state == S_ARMED && hit) begin
          triggered <= 1'b1;
          rem       <= pc;
        end
        if (state == S_POST) rem <= rem - CNT_W'(1);
        // Freeze: oldest entry sits fill samples behind the write pointer.
        if (do_wr && state_nxt == S_DONE) begin
          rd_ptr <= wr_ptr_inc - AW'(fill_inc);
          rd_cnt <= fill_inc;
        end
        if (load) begin
          rd_data <= mem[rd_ptr];
          rd_last <= (rd_cnt == CNT_W'(1));
          rd_vld  <= 1'b1;
          rd_ptr  <= rd_ptr + AW'(1);
          rd_cnt  <= rd_cnt - CNT_W'(1);
        end else if (xfer) begin
          rd_vld  <= 1'b0;
          rd_last <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dbg_trace_capture.sv
// Directed testbench for dbg_trace_capture (WIDTH=8, DEPTH=16, CNT_W=5).
module tb_dbg_trace_capture;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] din;
  logic       arm;
  logic [7:0] trig_val;
  logic [7:0] trig_msk;
  logic [4:0] post_cnt;
  logic       rd_vld;
  logic       rd_rdy;
  logic [7:0] rd_data;
  logic       rd_last;
  logic [1:0] state;
  logic       triggered;

  int total = 0;
  int bad   = 0;

  logic [7:0] got_data [$];
  logic       got_last [$];
  int         stalls;

  dbg_trace_capture #(.WIDTH(8), .DEPTH(16), .CNT_W(5)) dut (
    .clk(clk), .rstn(rstn), .din(din), .arm(arm),
    .trig_val(trig_val), .trig_msk(trig_msk), .post_cnt(post_cnt),
    .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_data(rd_data), .rd_last(rd_last),
    .state(state), .triggered(triggered)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_cap(input logic [7:0] tv, input logic [7:0] m, input logic [4:0] p);
    trig_val = tv;
    trig_msk = m;
    post_cnt = p;
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic run_ramp(input int start);
    int n = 0;
    int v = start;
    while (state != 2'd3 && n < 100) begin
      din = 8'(v);
      step();
      v++;
      n++;
    end
    din = 8'h00;
    total++;
    if (state !== 2'd3) begin
      bad++;
      $display("FAIL ramp_timeout state=%0d required=3", state);
    end
  endtask

  // Collect transfers; mode 1 randomises rd_rdy and tallies stall instability.
  task automatic drain(input int mode);
    int n = 0;
    logic done = 1'b0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic prev_last = 1'b0;
    got_data.delete();
    got_last.delete();
    stalls = 0;
    while (!done && n < 600) begin
      rd_rdy = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall && (rd_vld !== 1'b1 || rd_data !== prev_data || rd_last !== prev_last))
        stalls++;
      if (rd_vld && rd_rdy) begin
        got_data.push_back(rd_data);
        got_last.push_back(rd_last);
        done = rd_last;
      end
      prev_stall = rd_vld && !rd_rdy;
      prev_data  = rd_data;
      prev_last  = rd_last;
      step();
      n++;
    end
    rd_rdy = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain_timeout got=%0d samples, no rd_last", got_data.size());
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step();
    step();
    total++; if (state !== 2'd0)     begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
    total++; if (rd_vld !== 1'b0)    begin bad++; $display("FAIL rst_vld got=%b exp=0", rd_vld); end
    total++; if (rd_last !== 1'b0)   begin bad++; $display("FAIL rst_last got=%b exp=0", rd_last); end
    total++; if (rd_data !== 8'h00)  begin bad++; $display("FAIL rst_data got=%h exp=00", rd_data); end
    total++; if (triggered !== 1'b0) begin bad++; $display("FAIL rst_trig got=%b exp=0", triggered); end
    rstn = 1'b1;
    step();
    // Reset in the middle of POST.
    arm_cap(8'd3, 8'hFF, 5'd10);
    for (int i = 0; i < 6; i++) begin
      din = 8'(i);
      step();
    end
    total++; if (state !== 2'd2)     begin bad++; $display("FAIL post_state got=%0d exp=2", state); end
    total++; if (triggered !== 1'b1) begin bad++; $display("FAIL post_trig got=%b exp=1", triggered); end
    rstn = 1'b0;
    step();
    total++; if (state !== 2'd0)     begin bad++; $display("FAIL rst_post_state got=%0d exp=0", state); end
    total++; if (rd_vld !== 1'b0)    begin bad++; $display("FAIL rst_post_vld got=%b exp=0", rd_vld); end
    total++; if (triggered !== 1'b0) begin bad++; $display("FAIL rst_post_trig got=%b exp=0", triggered); end
    rstn = 1'b1;
    din = 8'h00;
    step();
    // Reset while a sample is being presented.
    arm_cap(8'd0, 8'hFF, 5'd0);
    run_ramp(0);
    rd_rdy = 1'b0;
    step();
    total++; if (rd_vld !== 1'b1)    begin bad++; $display("FAIL pre_rst_vld got=%b exp=1", rd_vld); end
    rstn = 1'b0;
    step();
    total++; if (state !== 2'd0)     begin bad++; $display("FAIL rst_drain_state got=%0d exp=0", state); end
    total++; if (rd_vld !== 1'b0)    begin bad++; $display("FAIL rst_drain_vld got=%b exp=0", rd_vld); end
    total++; if (triggered !== 1'b0) begin bad++; $display("FAIL rst_drain_trig got=%b exp=0", triggered); end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_ramp();
    arm_cap(8'h05, 8'hFF, 5'd2);
    run_ramp(0);
    total++; if (triggered !== 1'b1) begin bad++; $display("FAIL ramp_trig got=%b exp=1", triggered); end
    drain(0);
    total++; if (got_data.size() != 8) begin bad++; $display("FAIL ramp_size got=%0d exp=8", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== 8'(i) || got_last[i] !== (i == 7)) begin
        bad++;
        $display("FAIL ramp_sample%0d got=%h/%b exp=%h/%b", i, got_data[i], got_last[i], 8'(i), (i == 7));
      end
    end
    step();
    total++; if (state !== 2'd0)  begin bad++; $display("FAIL ramp_end_state got=%0d exp=0", state); end
    total++; if (rd_vld !== 1'b0) begin bad++; $display("FAIL ramp_end_vld got=%b exp=0", rd_vld); end
  endtask

  task automatic test_wrap();
    arm_cap(8'd40, 8'hFF, 5'd3);
    run_ramp(0);
    drain(0);
    total++; if (got_data.size() != 16) begin bad++; $display("FAIL wrap_size got=%0d exp=16", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== 8'(28 + i) || got_last[i] !== (i == 15)) begin
        bad++;
        $display("FAIL wrap_sample%0d got=%h/%b exp=%h/%b", i, got_data[i], got_last[i], 8'(28 + i), (i == 15));
      end
    end
  endtask

  task automatic test_clamp_mask();
    arm_cap(8'hAA, 8'h00, 5'd31);
    run_ramp(7);
    drain(0);
    total++; if (got_data.size() != 16) begin bad++; $display("FAIL clamp_size got=%0d exp=16", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== 8'(7 + i) || got_last[i] !== (i == 15)) begin
        bad++;
        $display("FAIL clamp_sample%0d got=%h/%b exp=%h/%b", i, got_data[i], got_last[i], 8'(7 + i), (i == 15));
      end
    end
  endtask

  task automatic test_backpressure();
    arm_cap(8'd60, 8'hFF, 5'd4);
    run_ramp(50);
    drain(1);
    total++; if (stalls != 0) begin bad++; $display("FAIL bp_stable got=%0d unstable stalls exp=0", stalls); end
    total++; if (got_data.size() != 15) begin bad++; $display("FAIL bp_size got=%0d exp=15", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== 8'(50 + i) || got_last[i] !== (i == 14)) begin
        bad++;
        $display("FAIL bp_sample%0d got=%h/%b exp=%h/%b", i, got_data[i], got_last[i], 8'(50 + i), (i == 14));
      end
    end
  endtask

  task automatic test_rearm();
    int xfers = 0;
    int n = 0;
    arm_cap(8'd105, 8'hFF, 5'd2);
    run_ramp(100);
    rd_rdy = 1'b1;
    while (xfers < 3 && n < 50) begin
      if (rd_vld) begin
        total++;
        if (rd_data !== 8'(100 + xfers)) begin
          bad++;
          $display("FAIL rearm_old%0d got=%h exp=%h", xfers, rd_data, 8'(100 + xfers));
        end
        xfers++;
      end
      step();
      n++;
    end
    rd_rdy = 1'b0;
    total++; if (rd_vld !== 1'b1) begin bad++; $display("FAIL rearm_pre_vld got=%b exp=1", rd_vld); end
    arm_cap(8'd202, 8'hFF, 5'd1);
    total++; if (rd_vld !== 1'b0)    begin bad++; $display("FAIL rearm_vld got=%b exp=0", rd_vld); end
    total++; if (state !== 2'd1)     begin bad++; $display("FAIL rearm_state got=%0d exp=1", state); end
    total++; if (triggered !== 1'b0) begin bad++; $display("FAIL rearm_trig got=%b exp=0", triggered); end
    run_ramp(200);
    drain(0);
    total++; if (got_data.size() != 4) begin bad++; $display("FAIL rearm_size got=%0d exp=4", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== 8'(200 + i) || got_last[i] !== (i == 3)) begin
        bad++;
        $display("FAIL rearm_sample%0d got=%h/%b exp=%h/%b", i, got_data[i], got_last[i], 8'(200 + i), (i == 3));
      end
    end
  endtask

  initial begin
    rstn     = 1'b0;
    din      = 8'h00;
    arm      = 1'b0;
    trig_val = 8'h00;
    trig_msk = 8'h00;
    post_cnt = 5'd0;
    rd_rdy   = 1'b0;
    test_reset();
    test_ramp();
    test_wrap();
    test_clamp_mask();
    test_backpressure();
    test_rearm();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
